// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle control unit.
// State codes, opcode constants, ALU/PC select encodings and the bundled
// control-output struct used inside mc_control_unit.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_JR     = 4'd10,
        S_LUI    = 4'd11,
        S_TRAP   = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_JR    = 6'b001000;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_LH    = 6'b100001;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_LBU   = 6'b100100;
    localparam logic [5:0] OP_LHU   = 6'b100101;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_SH    = 6'b101001;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PC_SEQ    = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;
    localparam logic [1:0] PC_JR     = 2'b11;

    localparam logic [1:0] LDC_WORD  = 2'b10;
    localparam logic [1:0] LDC_HALF  = 2'b01;
    localparam logic [1:0] LDC_BYTE  = 2'b00;
    localparam logic [1:0] STC_BYTE  = 2'b10;
    localparam logic [1:0] STC_HALF  = 2'b01;
    localparam logic [1:0] STC_WORD  = 2'b00;

    typedef struct packed {
        logic       pc_write;
        logic       ir_write;
        logic       iord;
        logic       memread;
        logic       memwrite;
        logic       memtoreg;
        logic       regwrite;
        logic       regdest;
        logic       alusrc_a;
        logic       lui_control;
        logic       jal_control;
        logic       extend;
        logic [1:0] alusrc_b;
        logic [1:0] aluop;
        logic [1:0] pc_src;
        logic [1:0] store_control;
        logic [1:0] load_control;
    } ctrl_t;

    // States that wait on mem_ready and are guarded by the timeout counter
    function automatic logic is_wait_state(state_t s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

    // States in which the load/store size and extend selects are driven
    function automatic logic is_mem_window(state_t s);
        return (s == S_MEMADR) || (s == S_MEMRD) || (s == S_MEMWB) || (s == S_MEMWR);
    endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational opcode classifier for mc_control_unit.
// Sub-word loads/stores (lb, lbu, lh, lhu, sb, sh) are only recognised when
// MC_CTRL_SUBWORD_EN is defined; otherwise they classify as illegal and the
// size selects are fixed at word load / no sub-word store.
module mc_ctrl_decode
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] op,
    output logic       is_load,
    output logic       is_store,
    output logic       is_rtype,
    output logic       is_beq,
    output logic       is_j,
    output logic       is_jal,
    output logic       is_jr,
    output logic       is_lui,
    output logic       is_illegal,
    output logic [1:0] load_size,
    output logic [1:0] store_size,
    output logic       ext
);

    // Instruction class and sign/zero extend select
    always_comb begin
        is_load    = 1'b0;
        is_store   = 1'b0;
        is_rtype   = 1'b0;
        is_beq     = 1'b0;
        is_j       = 1'b0;
        is_jal     = 1'b0;
        is_jr      = 1'b0;
        is_lui     = 1'b0;
        is_illegal = 1'b0;
        ext        = 1'b0;
        case (op)
            OP_LW:    begin is_load  = 1'b1; ext = 1'b1; end
            OP_SW:    begin is_store = 1'b1; ext = 1'b1; end
`ifdef MC_CTRL_SUBWORD_EN
            OP_LB:    is_load = 1'b1;
            OP_LH:    is_load = 1'b1;
            OP_LBU:   begin is_load  = 1'b1; ext = 1'b1; end
            OP_LHU:   begin is_load  = 1'b1; ext = 1'b1; end
            OP_SB:    begin is_store = 1'b1; ext = 1'b1; end
            OP_SH:    begin is_store = 1'b1; ext = 1'b1; end
`endif
            OP_RTYPE: is_rtype = 1'b1;
            OP_BEQ:   is_beq   = 1'b1;
            OP_J:     is_j     = 1'b1;
            OP_JAL:   begin is_j = 1'b1; is_jal = 1'b1; end
            OP_JR:    is_jr    = 1'b1;
            OP_LUI:   is_lui   = 1'b1;
            default:  is_illegal = 1'b1;
        endcase
    end

`ifdef MC_CTRL_SUBWORD_EN
    // Access size selects for the load/store datapath
    always_comb begin
        load_size  = LDC_BYTE;
        store_size = STC_WORD;
        case (op)
            OP_LW:         load_size  = LDC_WORD;
            OP_LH, OP_LHU: load_size  = LDC_HALF;
            OP_SB:         store_size = STC_BYTE;
            OP_SH:         store_size = STC_HALF;
            default:       ;
        endcase
    end
`else
    // Word-only build: sizes are constant
    assign load_size  = LDC_WORD;
    assign store_size = STC_WORD;
`endif

endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle MIPS-style control unit: Moore FSM over FETCH..TRAP with a
// memory-wait timeout trap and a sticky illegal-opcode trap.
// Optional sub-word load/store support: MC_CTRL_SUBWORD_EN (see mc_ctrl_decode).
// Outputs stay 0 for the whole cycle in which reset is released; the FSM
// starts running (and FETCH outputs appear) from the next cycle.
module mc_control_unit
    import mc_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    input  logic       zero,
    output logic       pc_write,
    output logic       ir_write,
    output logic       iord,
    output logic       memread,
    output logic       memwrite,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       regdest,
    output logic       alusrc_a,
    output logic       lui_control,
    output logic       jal_control,
    output logic       extend,
    output logic [1:0] alusrc_b,
    output logic [1:0] aluop,
    output logic [1:0] pc_src,
    output logic [1:0] store_control,
    output logic [1:0] load_control,
    output logic [3:0] state,
    output logic       illegal,
    output logic       timeout
);

    state_t           state_q, state_d;
    logic [5:0]       op_q;
    logic [CNT_W-1:0] wait_cnt;
    logic             run_q;
    logic             illegal_q, timeout_q;
    ctrl_t            c;

    logic             d_load, d_store, d_rtype, d_beq, d_j, d_jal, d_jr, d_lui, d_ill, d_ext;
    logic [1:0]       d_lsize, d_ssize;

    // The live opcode is only meaningful in DECODE; afterwards the latched copy drives decode
    logic [5:0] dec_op;
    assign dec_op = (state_q == S_DECODE) ? opcode : op_q;

    mc_ctrl_decode u_dec (
        .op         (dec_op),
        .is_load    (d_load),
        .is_store   (d_store),
        .is_rtype   (d_rtype),
        .is_beq     (d_beq),
        .is_j       (d_j),
        .is_jal     (d_jal),
        .is_jr      (d_jr),
        .is_lui     (d_lui),
        .is_illegal (d_ill),
        .load_size  (d_lsize),
        .store_size (d_ssize),
        .ext        (d_ext)
    );

    // Last waiting cycle of an access that still has no mem_ready
    logic expired;
    assign expired = is_wait_state(state_q) && !mem_ready
                     && (wait_cnt == CNT_W'(TIMEOUT - 1));

    // State register; FSM is held for the first cycle after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            run_q   <= 1'b0;
        end else begin
            run_q <= 1'b1;
            if (run_q) state_q <= state_d;
        end
    end

    // Opcode latch, wait counter and sticky trap flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q      <= '0;
            wait_cnt  <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else if (run_q) begin
            if (state_q == S_DECODE) op_q <= opcode;
            if (state_d != state_q)
                wait_cnt <= '0;
            else if (is_wait_state(state_q) && !mem_ready)
                wait_cnt <= wait_cnt + CNT_W'(1);
            if (state_q == S_DECODE && d_ill) illegal_q <= 1'b1;
            if (expired) timeout_q <= 1'b1;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  if (mem_ready) state_d = S_DECODE;
                      else if (expired) state_d = S_TRAP;
            S_DECODE: begin
                if (d_load || d_store) state_d = S_MEMADR;
                else if (d_rtype)      state_d = S_EXEC;
                else if (d_beq)        state_d = S_BRANCH;
                else if (d_j)          state_d = S_JUMP;
                else if (d_jr)         state_d = S_JR;
                else if (d_lui)        state_d = S_LUI;
                else                   state_d = S_TRAP;
            end
            S_MEMADR: state_d = d_load ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
                      else if (expired) state_d = S_TRAP;
            S_MEMWR:  if (mem_ready) state_d = S_FETCH;
                      else if (expired) state_d = S_TRAP;
            S_EXEC:   state_d = S_ALUWB;
            S_MEMWB, S_ALUWB, S_BRANCH, S_JUMP, S_JR, S_LUI:
                      state_d = S_FETCH;
            S_TRAP:   state_d = S_TRAP;
            default:  state_d = S_TRAP;
        endcase
    end

    // Output decode from state and latched opcode; all zero until running
    always_comb begin
        c = '0;
        case (state_q)
            S_FETCH: begin
                c.memread  = 1'b1;
                c.alusrc_b = 2'b01;
                c.aluop    = ALUOP_ADD;
                if (mem_ready) begin
                    c.ir_write = 1'b1;
                    c.pc_write = 1'b1;
                    c.pc_src   = PC_SEQ;
                end
            end
            S_DECODE: begin
                c.alusrc_b = 2'b11;
                c.aluop    = ALUOP_ADD;
            end
            S_MEMADR: begin
                c.alusrc_a = 1'b1;
                c.alusrc_b = 2'b10;
                c.aluop    = ALUOP_ADD;
            end
            S_MEMRD:  begin c.memread  = 1'b1; c.iord = 1'b1; end
            S_MEMWB:  begin c.regwrite = 1'b1; c.memtoreg = 1'b1; end
            S_MEMWR:  begin c.memwrite = 1'b1; c.iord = 1'b1; end
            S_EXEC: begin
                c.alusrc_a = 1'b1;
                c.alusrc_b = 2'b00;
                c.aluop    = ALUOP_FUNCT;
            end
            S_ALUWB:  begin c.regwrite = 1'b1; c.regdest = 1'b1; end
            S_BRANCH: begin
                c.alusrc_a = 1'b1;
                c.alusrc_b = 2'b00;
                c.aluop    = ALUOP_SUB;
                c.pc_src   = PC_BRANCH;
                c.pc_write = zero;
            end
            S_JUMP: begin
                c.pc_src   = PC_JUMP;
                c.pc_write = 1'b1;
                if (d_jal) begin
                    c.jal_control = 1'b1;
                    c.regwrite    = 1'b1;
                end
            end
            S_JR:     begin c.pc_src = PC_JR; c.pc_write = 1'b1; end
            S_LUI:    begin c.lui_control = 1'b1; c.regwrite = 1'b1; end
            default:  ;
        endcase
        if (is_mem_window(state_q)) begin
            c.extend        = d_ext;
            c.load_control  = d_lsize;
            c.store_control = d_ssize;
        end
        if (!run_q) c = '0;
    end

    assign pc_write      = c.pc_write;
    assign ir_write      = c.ir_write;
    assign iord          = c.iord;
    assign memread       = c.memread;
    assign memwrite      = c.memwrite;
    assign memtoreg      = c.memtoreg;
    assign regwrite      = c.regwrite;
    assign regdest       = c.regdest;
    assign alusrc_a      = c.alusrc_a;
    assign lui_control   = c.lui_control;
    assign jal_control   = c.jal_control;
    assign extend        = c.extend;
    assign alusrc_b      = c.alusrc_b;
    assign aluop         = c.aluop;
    assign pc_src        = c.pc_src;
    assign store_control = c.store_control;
    assign load_control  = c.load_control;
    assign state         = state_q;
    assign illegal       = illegal_q;
    assign timeout       = timeout_q;

endmodule

// File: tb/tb_mc_control_unit.sv
// Self-checking bench for mc_control_unit (TIMEOUT=4). A cycle-level reference
// walks each instruction through its spec'd state path, driving mem_ready
// wait counts, and checks state, all controls and trap flags every cycle.
module tb_mc_control_unit;
    import mc_ctrl_pkg::*;

    localparam int TO = 4;

    localparam int C_ILL = 0, C_LOAD = 1, C_STORE = 2, C_RTYPE = 3,
                   C_BEQ = 4, C_JUMP = 5, C_JR = 6, C_LUI = 7;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode = '0;
    logic       mem_ready = 1'b0;
    logic       zero = 1'b0;
    logic       pc_write, ir_write, iord, memread, memwrite, memtoreg, regwrite, regdest;
    logic       alusrc_a, lui_control, jal_control, extend;
    logic [1:0] alusrc_b, aluop, pc_src, store_control, load_control;
    logic [3:0] state;
    logic       illegal, timeout;

    int n_asrt = 0;
    int n_fail = 0;
    bit m_ill = 1'b0;
    bit m_to  = 1'b0;

    mc_control_unit #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready), .zero(zero),
        .pc_write(pc_write), .ir_write(ir_write), .iord(iord), .memread(memread),
        .memwrite(memwrite), .memtoreg(memtoreg), .regwrite(regwrite), .regdest(regdest),
        .alusrc_a(alusrc_a), .lui_control(lui_control), .jal_control(jal_control),
        .extend(extend), .alusrc_b(alusrc_b), .aluop(aluop), .pc_src(pc_src),
        .store_control(store_control), .load_control(load_control),
        .state(state), .illegal(illegal), .timeout(timeout)
    );

    always #5 clk = ~clk;

    logic [21:0] obs_ctrl;
    assign obs_ctrl = {pc_write, ir_write, iord, memread, memwrite, memtoreg, regwrite,
                       regdest, alusrc_a, lui_control, jal_control, extend,
                       alusrc_b, aluop, pc_src, store_control, load_control};

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    function automatic int class_of(logic [5:0] op);
        case (op)
            6'b100011: return C_LOAD;
            6'b101011: return C_STORE;
`ifdef MC_CTRL_SUBWORD_EN
            6'b100000, 6'b100100, 6'b100001, 6'b100101: return C_LOAD;
            6'b101000, 6'b101001: return C_STORE;
`endif
            6'b000000: return C_RTYPE;
            6'b000100: return C_BEQ;
            6'b000010, 6'b000011: return C_JUMP;
            6'b001000: return C_JR;
            6'b001111: return C_LUI;
            default:   return C_ILL;
        endcase
    endfunction

    // Expected control vector for a state, from the per-state output lists
    function automatic logic [21:0] exp_ctrl(state_t s, logic [5:0] op, logic rdy, logic z);
        logic pcw, irw, iod, mrd, mwr, m2r, rw, rd, asa, lui, jal, ext;
        logic [1:0] asb, aop, psrc, stc, ldc;
        {pcw, irw, iod, mrd, mwr, m2r, rw, rd, asa, lui, jal, ext} = '0;
        {asb, aop, psrc, stc, ldc} = '0;
        case (s)
            S_FETCH:  begin mrd = 1; asb = 2'b01; irw = rdy; pcw = rdy; end
            S_DECODE: asb = 2'b11;
            S_MEMADR: begin asa = 1; asb = 2'b10; end
            S_MEMRD:  begin mrd = 1; iod = 1; end
            S_MEMWB:  begin rw = 1; m2r = 1; end
            S_MEMWR:  begin mwr = 1; iod = 1; end
            S_EXEC:   begin asa = 1; aop = 2'b10; end
            S_ALUWB:  begin rw = 1; rd = 1; end
            S_BRANCH: begin asa = 1; aop = 2'b01; psrc = 2'b01; pcw = z; end
            S_JUMP:   begin psrc = 2'b10; pcw = 1; if (op == 6'b000011) begin jal = 1; rw = 1; end end
            S_JR:     begin psrc = 2'b11; pcw = 1; end
            S_LUI:    begin lui = 1; rw = 1; end
            default:  ;
        endcase
        if (s == S_MEMADR || s == S_MEMRD || s == S_MEMWB || s == S_MEMWR) begin
            ext = op inside {6'b100011, 6'b101011, 6'b100100, 6'b100101, 6'b101000, 6'b101001};
`ifdef MC_CTRL_SUBWORD_EN
            ldc = (op == 6'b100011) ? 2'b10 : (op inside {6'b100001, 6'b100101}) ? 2'b01 : 2'b00;
            stc = (op == 6'b101000) ? 2'b10 : (op == 6'b101001) ? 2'b01 : 2'b00;
`else
            ldc = 2'b10;
            stc = 2'b00;
`endif
        end
        return {pcw, irw, iod, mrd, mwr, m2r, rw, rd, asa, lui, jal, ext, asb, aop, psrc, stc, ldc};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One cycle: drive inputs at negedge, check outputs 1 time unit later
    task automatic step(input state_t s, input logic [5:0] op, input logic rdy, input logic z);
        @(negedge clk);
        mem_ready = rdy;
        zero      = z;
        opcode    = (s == S_DECODE) ? op : 6'($urandom);
        #1;
        chk({s.name(), " state"}, 32'(state), 32'(s));
        chk({s.name(), " ctrl"}, 32'(obs_ctrl), 32'(exp_ctrl(s, op, rdy, z)));
        chk({s.name(), " illegal"}, 32'(illegal), 32'(m_ill));
        chk({s.name(), " timeout"}, 32'(timeout), 32'(m_to));
    endtask

    // Memory access with w not-ready cycles; w >= TO ends in a timeout trap
    task automatic access(input state_t s, input logic [5:0] op, input int w, output bit ok);
        ok = 1'b1;
        for (int i = 0; i < TO; i++) begin
            if (i == w) begin
                step(s, op, 1'b1, rb());
                return;
            end
            step(s, op, 1'b0, rb());
        end
        m_to = 1'b1;
        ok   = 1'b0;
    endtask

    task automatic do_reset(input bit now);
        if (!now) @(negedge clk);
        rst_n = 1'b0;
        mem_ready = 1'b0;
        #1;
        m_ill = 1'b0;
        m_to  = 1'b0;
        chk("rst state", 32'(state), 32'(S_FETCH));
        chk("rst ctrl", 32'(obs_ctrl), 32'd0);
        chk("rst illegal", 32'(illegal), 32'd0);
        chk("rst timeout", 32'(timeout), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("release ctrl", 32'(obs_ctrl), 32'd0);
        chk("release state", 32'(state), 32'(S_FETCH));
    endtask

    task automatic trap_tail();
        for (int i = 0; i < 3; i++) step(S_TRAP, 6'd0, rb(), rb());
        do_reset(1'b0);
    endtask

    task automatic run_instr(input logic [5:0] op, input int wf, input int wm, input logic z);
        bit ok;
        access(S_FETCH, op, wf, ok);
        if (!ok) begin
            trap_tail();
            return;
        end
        step(S_DECODE, op, rb(), rb());
        case (class_of(op))
            C_LOAD: begin
                step(S_MEMADR, op, rb(), rb());
                access(S_MEMRD, op, wm, ok);
                if (ok) step(S_MEMWB, op, rb(), rb());
            end
            C_STORE: begin
                step(S_MEMADR, op, rb(), rb());
                access(S_MEMWR, op, wm, ok);
            end
            C_RTYPE: begin
                step(S_EXEC, op, rb(), rb());
                step(S_ALUWB, op, rb(), rb());
            end
            C_BEQ:  step(S_BRANCH, op, rb(), z);
            C_JUMP: step(S_JUMP, op, rb(), rb());
            C_JR:   step(S_JR, op, rb(), rb());
            C_LUI:  step(S_LUI, op, rb(), rb());
            default: begin
                m_ill = 1'b1;
                ok    = 1'b0;
            end
        endcase
        if (!ok) trap_tail();
    endtask

    function automatic logic [5:0] pick_op(int k);
        case (k)
            0: return 6'b100011;  1: return 6'b100000;  2: return 6'b100100;
            3: return 6'b100001;  4: return 6'b100101;  5: return 6'b101011;
            6: return 6'b101000;  7: return 6'b101001;  8: return 6'b000000;
            9: return 6'b000100; 10: return 6'b000010; 11: return 6'b000011;
            12: return 6'b001000; 13: return 6'b001111;
            default: return 6'($urandom);
        endcase
    endfunction

    initial begin
        do_reset(1'b0);
        // lw with immediate memory: 5-cycle path
        run_instr(6'b100011, 0, 0, 1'b0);
        // beq not taken then taken
        run_instr(6'b000100, 0, 0, 1'b0);
        run_instr(6'b000100, 1, 0, 1'b1);
        // sw: ready on the last allowed wait cycle, then a full timeout
        run_instr(6'b101011, 0, TO - 1, 1'b0);
        run_instr(6'b101011, 0, TO, 1'b0);
        // fetch timeout
        run_instr(6'b000000, TO, 0, 1'b0);
        // illegal opcode is absorbing until reset
        run_instr(6'b111111, 0, 0, 1'b0);
        // sh: sub-word store or illegal depending on build
        run_instr(6'b101001, 0, 1, 1'b0);
        run_instr(6'b000000, 0, 0, 1'b0);
        run_instr(6'b000010, 0, 0, 1'b0);
        run_instr(6'b000011, 0, 0, 1'b0);
        run_instr(6'b001000, 0, 0, 1'b0);
        run_instr(6'b001111, 0, 0, 1'b0);
        // reset asserted while a load is waiting in MEMRD
        step(S_FETCH, 6'b100011, 1'b1, 1'b0);
        step(S_DECODE, 6'b100011, 1'b0, 1'b0);
        step(S_MEMADR, 6'b100011, 1'b0, 1'b0);
        step(S_MEMRD, 6'b100011, 1'b0, 1'b0);
        do_reset(1'b1);
        run_instr(6'b100011, 1, 2, 1'b0);
        // randomized instruction stream
        for (int n = 0; n < 60; n++) begin
            int k, wf, wm;
            k  = $urandom_range(0, 15);
            wf = ($urandom_range(0, 11) == 0) ? TO : $urandom_range(0, 2);
            wm = ($urandom_range(0, 7) == 0)  ? TO : $urandom_range(0, TO - 1);
            run_instr(pick_op(k), wf, wm, rb());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, observed running expected done");
        $fatal(1, "watchdog");
    end

endmodule
